// File: rtl/uart_pkg.sv
// +----------------------------------------------------------------------------+
// | uart_pkg                                                                   |
// | Shared types and constants for the UART transmit path.                     |
// | Optional feature macro: UART_TX_PARITY_EN (adds the even-parity state).    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
      ST_PARITY = 3'd4,
`endif
      ST_STOP   = 3'd3
   } uart_tx_state_t;

   // Divider values for the 100 MHz board clock.
   localparam int UART_BAUD_DIV_115200 = 868;
   localparam int UART_BAUD_DIV_9600   = 10417;

`ifdef UART_TX_PARITY_EN
   localparam int UART_FRAME_BITS = 11;
`else
   localparam int UART_FRAME_BITS = 10;
`endif

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// +----------------------------------------------------------------------------+
// | sync_fifo                                                                  |
// | Single-clock FIFO with show-ahead read data and an occupancy count.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      count
);

   localparam logic [AW:0] c_full_count = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_wr;
   logic             w_rd;

   // Full/empty come from the registered count, so a same-cycle read never frees a slot for a write.
   assign full    = (r_count == c_full_count);
   assign empty   = (r_count == '0);
   assign count   = r_count;
   assign rd_data = r_mem[r_rd_ptr];
   assign w_wr    = wr_en & ~full;
   assign w_rd    = rd_en & ~empty;

   always_ff @(posedge CLK) begin
      if (w_wr) begin
         r_mem[r_wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_rd) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         if (w_wr && !w_rd) begin
            r_count <= r_count + 1'b1;
         end else if (w_rd && !w_wr) begin
            r_count <= r_count - 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/uart_tx_fifo.sv
// +----------------------------------------------------------------------------+
// | uart_tx_fifo                                                               |
// | Buffered UART transmitter: start-edge push into a FIFO, LSB-first framing. |
// | Optional feature macro: UART_TX_PARITY_EN (8E1 instead of 8N1).            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int BAUD_DIV   = UART_BAUD_DIV_115200,
   parameter int FIFO_DEPTH = 4
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       start,
   input  logic [7:0] data,
   output logic       ready,
   output logic       busy,
   output logic       Tx
);

   localparam int                c_baud_w    = $clog2(BAUD_DIV);
   localparam int                c_fifo_aw   = $clog2(FIFO_DEPTH);
   localparam logic [c_baud_w-1:0] c_baud_last = c_baud_w'(BAUD_DIV - 1);

   uart_tx_state_t      r_state;
   uart_tx_state_t      w_state_nxt;
   logic [c_baud_w-1:0] r_baud;
   logic [c_baud_w-1:0] w_baud_nxt;
   logic                w_baud_last;
   logic [2:0]          r_bit;
   logic [2:0]          w_bit_nxt;
   logic [7:0]          r_shift;
   logic [7:0]          w_shift_nxt;
   logic                r_tx;
   logic                w_tx_nxt;
   logic                r_start_q;
   logic                w_push;
   logic                w_pop;
   logic [7:0]          w_fifo_rd_data;
   logic                w_fifo_full;
   logic                w_fifo_empty;
   logic [c_fifo_aw:0]  w_fifo_count;
`ifdef UART_TX_PARITY_EN
   logic                r_parity;
`endif

   assign w_push      = start & ~r_start_q;
   assign w_baud_last = (r_baud == c_baud_last);
   assign ready       = ~w_fifo_full;
   assign busy        = (r_state != ST_IDLE) | (w_fifo_count != '0);
   assign Tx          = r_tx;

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .CLK     (CLK),
      .RST     (RST),
      .wr_en   (w_push),
      .wr_data (data),
      .rd_en   (w_pop),
      .rd_data (w_fifo_rd_data),
      .full    (w_fifo_full),
      .empty   (w_fifo_empty),
      .count   (w_fifo_count)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_baud_nxt  = r_baud;
      w_bit_nxt   = r_bit;
      w_shift_nxt = r_shift;
      w_pop       = 1'b0;
      if (r_state != ST_IDLE) begin
         w_baud_nxt = w_baud_last ? '0 : r_baud + 1'b1;
      end
      case (r_state)
         ST_IDLE: begin
            if (!w_fifo_empty) begin
               w_pop       = 1'b1;
               w_shift_nxt = w_fifo_rd_data;
               w_baud_nxt  = '0;
               w_state_nxt = ST_START;
            end
         end
         ST_START: begin
            if (w_baud_last) begin
               w_bit_nxt   = 3'd0;
               w_state_nxt = ST_DATA;
            end
         end
         ST_DATA: begin
            if (w_baud_last) begin
               w_shift_nxt = r_shift >> 1;
               if (r_bit == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  w_state_nxt = ST_PARITY;
`else
                  w_state_nxt = ST_STOP;
`endif
               end else begin
                  w_bit_nxt = r_bit + 3'd1;
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         ST_PARITY: begin
            if (w_baud_last) begin
               w_state_nxt = ST_STOP;
            end
         end
`endif
         ST_STOP: begin
            // Chain straight into the next start bit when more data is queued.
            if (w_baud_last) begin
               if (!w_fifo_empty) begin
                  w_pop       = 1'b1;
                  w_shift_nxt = w_fifo_rd_data;
                  w_state_nxt = ST_START;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Line level follows the next state so Tx changes on the same edge as the state.
   always_comb begin
      w_tx_nxt = 1'b1;
      case (w_state_nxt)
         ST_START:  w_tx_nxt = 1'b0;
         ST_DATA:   w_tx_nxt = w_shift_nxt[0];
`ifdef UART_TX_PARITY_EN
         ST_PARITY: w_tx_nxt = r_parity;
`endif
         default:   w_tx_nxt = 1'b1;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state   <= ST_IDLE;
         r_baud    <= '0;
         r_bit     <= 3'd0;
         r_shift   <= 8'd0;
         r_tx      <= 1'b1;
         r_start_q <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_baud    <= w_baud_nxt;
         r_bit     <= w_bit_nxt;
         r_shift   <= w_shift_nxt;
         r_tx      <= w_tx_nxt;
         r_start_q <= start;
      end
   end

`ifdef UART_TX_PARITY_EN
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_parity <= 1'b0;
      end else if (w_pop) begin
         r_parity <= ^w_fifo_rd_data;
      end
   end
`endif

endmodule

`default_nettype wire
